// File: rtl/time_stepper.sv
// time_stepper: timestamp generator for the logic-analyzer capture path.
//
// While run is high, the block divides clk by an effective period
// P = max(prescaler, 1) and advances the time counter data once per period.
// Dropping run returns everything to time zero on the next rising edge.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   prescaler  clock cycles per time step (0 and 1 both mean every clock)
//   run        level enable: high counts, low clears to time zero
//   data       current timestamp (registered)
//   tick       one-cycle pulse in the cycle data shows a new value
//   overflow   sticky flag, set when data wraps from all-ones to zero
module time_stepper #(
    parameter int TIME_LENGTH     = 24,
    parameter int PRESCALER_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    input  logic                       run,
    output logic [TIME_LENGTH-1:0]     data,
    output logic                       tick,
    output logic                       overflow
);

    logic [PRESCALER_WIDTH-1:0] pc;
    logic [PRESCALER_WIDTH-1:0] period_m1;
    logic                       step;

    // P-1 with P = max(prescaler, 1); a zero prescaler behaves like 1.
    always_comb begin
        period_m1 = '0;
        if (prescaler != '0) begin
            period_m1 = prescaler - PRESCALER_WIDTH'(1);
        end
    end

    // Greater-or-equal so that shrinking the prescaler mid-run below the
    // current count steps on the next edge instead of waiting for pc to wrap.
    assign step = (pc >= period_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            data     <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else if (!run) begin
            pc       <= '0;
            data     <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else if (step) begin
            pc   <= '0;
            data <= data + TIME_LENGTH'(1);
            tick <= 1'b1;
            if (&data) begin
                overflow <= 1'b1;
            end
        end else begin
            pc   <= pc + PRESCALER_WIDTH'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_time_stepper.sv
// Testbench for time_stepper. Two instances share all inputs: one with the
// default 24-bit counter and one with a 4-bit counter for wrap-around.
// A reference model counts total steps in the current run; data and
// overflow are derived from that count arithmetically.
module tb_time_stepper;

    logic        clk;
    logic        rst_n;
    logic [31:0] prescaler;
    logic        run;
    logic [23:0] data24;
    logic        tick24;
    logic        ovf24;
    logic [3:0]  data4;
    logic        tick4;
    logic        ovf4;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model state
    longint m_steps;
    longint m_since;
    bit     m_tick;

    time_stepper #(.TIME_LENGTH(24), .PRESCALER_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .prescaler(prescaler), .run(run),
        .data(data24), .tick(tick24), .overflow(ovf24)
    );

    time_stepper #(.TIME_LENGTH(4), .PRESCALER_WIDTH(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .prescaler(prescaler), .run(run),
        .data(data4), .tick(tick4), .overflow(ovf4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: counts clocks since the last step and total steps.
    function automatic longint eff_period(input logic [31:0] p);
        return (p == 32'd0) ? 64'd1 : longint'(p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_steps <= 0;
            m_since <= 0;
            m_tick  <= 1'b0;
        end else if (!run) begin
            m_steps <= 0;
            m_since <= 0;
            m_tick  <= 1'b0;
        end else if (m_since + 1 >= eff_period(prescaler)) begin
            m_steps <= m_steps + 1;
            m_since <= 0;
            m_tick  <= 1'b1;
        end else begin
            m_since <= m_since + 1;
            m_tick  <= 1'b0;
        end
    end

    // Scoreboard: compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data24", 64'(data24), 64'(m_steps % (64'd1 << 24)));
            check("tick24", 64'(tick24), 64'(m_tick));
            check("ovf24",  64'(ovf24),  64'(m_steps >= (64'd1 << 24)));
            check("data4",  64'(data4),  64'(m_steps % 16));
            check("tick4",  64'(tick4),  64'(m_tick));
            check("ovf4",   64'(ovf4),   64'(m_steps >= 16));
        end
    end

    // driver tasks
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_run();
        run = 1'b0;
        edges(1);
    endtask

    initial begin
        int tcnt;
        rst_n     = 1'b0;
        run       = 1'b0;
        prescaler = 32'd0;
        edges(2);
        check("reset_data", 64'(data24), 64'd0);
        check("reset_tick", 64'(tick24), 64'd0);
        check("reset_ovf",  64'(ovf24),  64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        edges(1);

        // basic count, P=5
        prescaler = 32'd5;
        run       = 1'b1;
        tcnt      = 0;
        for (int i = 1; i <= 100; i++) begin
            edges(1);
            if (tick24) tcnt++;
            if (i == 4) check("basic_d4", 64'(data24), 64'd0);
            if (i == 5) check("basic_d5", 64'(data24), 64'd1);
        end
        check("basic_d100", 64'(data24), 64'd20);
        check("basic_ticks", 64'(tcnt), 64'd20);
        clear_run();
        check("basic_clear", 64'(data24), 64'd0);

        // degenerate prescalers 0 and 1
        for (int p = 0; p < 2; p++) begin
            prescaler = 32'(p);
            run       = 1'b1;
            tcnt      = 0;
            for (int i = 0; i < 10; i++) begin
                edges(1);
                if (tick24) tcnt++;
            end
            check("degen_data", 64'(data24), 64'd10);
            check("degen_ticks", 64'(tcnt), 64'd10);
            clear_run();
        end

        // wrap / overflow on the 4-bit instance
        prescaler = 32'd1;
        run       = 1'b1;
        edges(15);
        check("wrap_d15", 64'(data4), 64'd15);
        check("wrap_o15", 64'(ovf4), 64'd0);
        edges(1);
        check("wrap_d16", 64'(data4), 64'd0);
        check("wrap_o16", 64'(ovf4), 64'd1);
        check("wrap_t16", 64'(tick4), 64'd1);
        edges(1);
        check("wrap_d17", 64'(data4), 64'd1);
        check("wrap_o17", 64'(ovf4), 64'd1);
        check("wrap_d24", 64'(data24), 64'd17);
        clear_run();
        check("wrap_oclr", 64'(ovf4), 64'd0);

        // prescaler decrease mid-run
        prescaler = 32'd10;
        run       = 1'b1;
        edges(7);
        check("chg_pre", 64'(data24), 64'd0);
        prescaler = 32'd2;
        edges(1);
        check("chg_tick1", 64'(tick24), 64'd1);
        check("chg_d1", 64'(data24), 64'd1);
        edges(1);
        check("chg_tick2", 64'(tick24), 64'd0);
        edges(1);
        check("chg_tick3", 64'(tick24), 64'd1);
        check("chg_d2", 64'(data24), 64'd2);
        clear_run();

        // one-cycle run pulse with P=1
        prescaler = 32'd1;
        run       = 1'b1;
        edges(1);
        check("pulse_d1", 64'(data24), 64'd1);
        clear_run();
        check("pulse_d0", 64'(data24), 64'd0);

        // restart: data=3, drop run for a cycle, restart with P=3
        run = 1'b1;
        edges(3);
        check("rst_d3", 64'(data24), 64'd3);
        clear_run();
        check("rst_low", 64'(data24), 64'd0);
        prescaler = 32'd3;
        run       = 1'b1;
        edges(2);
        check("rst_e2", 64'(data24), 64'd0);
        edges(1);
        check("rst_e3", 64'(data24), 64'd1);

        // asynchronous reset mid-cycle with data nonzero
        prescaler = 32'd1;
        edges(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_data", 64'(data24), 64'd0);
        check("areset_tick", 64'(tick24), 64'd0);
        check("areset_ovf4", 64'(ovf4), 64'd0);
        edges(1);
        rst_n = 1'b1;
        edges(1);

        // randomized run: scoreboard compares every cycle
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: prescaler = 32'd0;
                    1: prescaler = 32'hFFFF_FFFF;
                    default: prescaler = $urandom_range(1, 6);
                endcase
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            edges(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
